// File: rtl/gps_sample_packer.sv
// gps_sample_packer
//   Synchronises NCH raw GPS sample lanes, packs the samples captured on
//   SAMPLE_STB into WORD_W-bit words (first sample in the top bits), buffers
//   the words in a FIFO and drains them to the MCU as fixed-length SPI mode-0
//   frames of WORDS_PER_FRAME words.
//
// Ports
//   MCU_CLK_25_000  sole clock
//   RESET_N         asynchronous active-low reset
//   GPS_DATA        raw asynchronous lanes, lane k at [k*BITS +: BITS]
//   SAMPLE_STB      one-cycle capture pulse (synchronous)
//   ENABLE          capture enable; low discards any partial word
//   MCU_SCK         SPI clock, idles low
//   MCU_SS          SPI select, active low
//   MCU_MOSI        SPI data, MSB first
//   OVERFLOW        sticky: a completed word was dropped on a full FIFO
//   FIFO_LEVEL      words currently buffered
//
// SPI FSM
//   state | meaning
//   IDLE  | waiting for a full frame's worth of words in the FIFO
//   LOAD  | SS low, first word loaded, MOSI = its MSB
//   LOW   | SCK low for SCK_DIV cycles
//   HIGH  | SCK high for SCK_DIV cycles; falling edge shifts / pops / ends
//   GAP   | SS high for 2*SCK_DIV cycles between frames
module gps_sample_packer #(
    parameter int NCH             = 2,
    parameter int BITS            = 2,
    parameter int WORD_W          = 16,
    parameter int FIFO_DEPTH      = 16,
    parameter int SCK_DIV         = 2,
    parameter int WORDS_PER_FRAME = 4
) (
    input  logic                          MCU_CLK_25_000,
    input  logic                          RESET_N,
    input  logic [NCH*BITS-1:0]           GPS_DATA,
    input  logic                          SAMPLE_STB,
    input  logic                          ENABLE,
    output logic                          MCU_SCK,
    output logic                          MCU_SS,
    output logic                          MCU_MOSI,
    output logic                          OVERFLOW,
    output logic [$clog2(FIFO_DEPTH):0]   FIFO_LEVEL
);

    localparam int SW  = NCH * BITS;
    localparam int SPW = WORD_W / SW;
    localparam int CW  = (SPW > 1) ? $clog2(SPW) : 1;
    localparam int AW  = $clog2(FIFO_DEPTH);
    localparam int DW  = $clog2(2 * SCK_DIV);
    localparam int BW  = $clog2(WORD_W);
    localparam int WCW = $clog2(WORDS_PER_FRAME + 1);

    typedef enum logic [2:0] {ST_IDLE, ST_LOAD, ST_LOW, ST_HIGH, ST_GAP} state_t;

    logic [SW-1:0]     gps_s1_q, gps_s1_d, gps_s2_q, gps_s2_d;
    logic [WORD_W-1:0] pack_q, pack_d;
    logic [CW-1:0]     cnt_q, cnt_d;
    logic              word_valid_q, word_valid_d;
    logic [AW:0]       wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
    logic              overflow_q, overflow_d;
    state_t            state_q, state_d;
    logic [DW-1:0]     div_q, div_d;
    logic [BW-1:0]     bit_q, bit_d;
    logic [WCW-1:0]    wcnt_q, wcnt_d;
    logic [WORD_W-1:0] shift_q, shift_d;
    logic              sck_q, sck_d, ss_q, ss_d, mosi_q, mosi_d;

    logic [WORD_W-1:0] mem_q [FIFO_DEPTH];
    logic [WORD_W-1:0] rd_word;
    logic [AW:0]       level;
    logic              full, pop, push_ok;

    assign level   = wr_ptr_q - rd_ptr_q;
    assign full    = (level == (AW+1)'(FIFO_DEPTH));
    assign rd_word = mem_q[rd_ptr_q[AW-1:0]];
    // A pop in the same cycle frees a slot, so a full FIFO still accepts.
    assign push_ok = word_valid_q && (!full || pop);

    always_comb begin
        gps_s1_d     = GPS_DATA;
        gps_s2_d     = gps_s1_q;
        pack_d       = pack_q;
        cnt_d        = cnt_q;
        word_valid_d = 1'b0;
        if (!ENABLE) begin
            pack_d = '0;
            cnt_d  = '0;
        end else if (SAMPLE_STB) begin
            pack_d = (pack_q << SW) | WORD_W'(gps_s2_q);
            if (cnt_q == CW'(SPW - 1)) begin
                cnt_d        = '0;
                word_valid_d = 1'b1;
            end else begin
                cnt_d = cnt_q + CW'(1);
            end
        end
    end

    always_comb begin
        state_d = state_q;
        div_d   = div_q;
        bit_d   = bit_q;
        wcnt_d  = wcnt_q;
        shift_d = shift_q;
        sck_d   = sck_q;
        ss_d    = ss_q;
        mosi_d  = mosi_q;
        pop     = 1'b0;
        case (state_q)
            ST_IDLE: begin
                // The first word is popped on the edge into LOAD so that SS,
                // MOSI and the shift register are already valid during LOAD.
                if (32'(level) >= 32'(WORDS_PER_FRAME)) begin
                    state_d = ST_LOAD;
                    pop     = 1'b1;
                    shift_d = rd_word;
                    mosi_d  = rd_word[WORD_W-1];
                    ss_d    = 1'b0;
                    bit_d   = BW'(WORD_W - 1);
                    wcnt_d  = '0;
                end
            end
            ST_LOAD: begin
                state_d = ST_LOW;
                div_d   = DW'(SCK_DIV - 1);
            end
            ST_LOW: begin
                if (div_q == '0) begin
                    state_d = ST_HIGH;
                    sck_d   = 1'b1;
                    div_d   = DW'(SCK_DIV - 1);
                end else begin
                    div_d = div_q - DW'(1);
                end
            end
            ST_HIGH: begin
                if (div_q == '0) begin
                    sck_d   = 1'b0;
                    state_d = ST_LOW;
                    div_d   = DW'(SCK_DIV - 1);
                    if (bit_q != '0) begin
                        shift_d = shift_q << 1;
                        mosi_d  = shift_q[WORD_W-2];
                        bit_d   = bit_q - BW'(1);
                    end else if (wcnt_q != WCW'(WORDS_PER_FRAME - 1)) begin
                        pop     = 1'b1;
                        shift_d = rd_word;
                        mosi_d  = rd_word[WORD_W-1];
                        bit_d   = BW'(WORD_W - 1);
                        wcnt_d  = wcnt_q + WCW'(1);
                    end else begin
                        ss_d    = 1'b1;
                        mosi_d  = 1'b0;
                        state_d = ST_GAP;
                        div_d   = DW'(2 * SCK_DIV - 1);
                    end
                end else begin
                    div_d = div_q - DW'(1);
                end
            end
            ST_GAP: begin
                if (div_q == '0) begin
                    state_d = ST_IDLE;
                end else begin
                    div_d = div_q - DW'(1);
                end
            end
            default: state_d = ST_IDLE;
        endcase
        wr_ptr_d   = wr_ptr_q + (AW+1)'(push_ok);
        rd_ptr_d   = rd_ptr_q + (AW+1)'(pop);
        overflow_d = overflow_q | (word_valid_q & ~push_ok);
    end

    always_ff @(posedge MCU_CLK_25_000 or negedge RESET_N) begin
        if (!RESET_N) begin
            gps_s1_q     <= '0;
            gps_s2_q     <= '0;
            pack_q       <= '0;
            cnt_q        <= '0;
            word_valid_q <= 1'b0;
            wr_ptr_q     <= '0;
            rd_ptr_q     <= '0;
            overflow_q   <= 1'b0;
            state_q      <= ST_IDLE;
            div_q        <= '0;
            bit_q        <= '0;
            wcnt_q       <= '0;
            shift_q      <= '0;
            sck_q        <= 1'b0;
            ss_q         <= 1'b1;
            mosi_q       <= 1'b0;
        end else begin
            gps_s1_q     <= gps_s1_d;
            gps_s2_q     <= gps_s2_d;
            pack_q       <= pack_d;
            cnt_q        <= cnt_d;
            word_valid_q <= word_valid_d;
            wr_ptr_q     <= wr_ptr_d;
            rd_ptr_q     <= rd_ptr_d;
            overflow_q   <= overflow_d;
            state_q      <= state_d;
            div_q        <= div_d;
            bit_q        <= bit_d;
            wcnt_q       <= wcnt_d;
            shift_q      <= shift_d;
            sck_q        <= sck_d;
            ss_q         <= ss_d;
            mosi_q       <= mosi_d;
        end
    end

    // pack_q holds the completed word for exactly the cycle word_valid_q is set.
    always_ff @(posedge MCU_CLK_25_000) begin
        if (push_ok) begin
            mem_q[wr_ptr_q[AW-1:0]] <= pack_q;
        end
    end

    assign MCU_SCK    = sck_q;
    assign MCU_SS     = ss_q;
    assign MCU_MOSI   = mosi_q;
    assign OVERFLOW   = overflow_q;
    assign FIFO_LEVEL = level;

endmodule

// File: tb/tb_gps_sample_packer.sv
// tb_gps_sample_packer
//   Directed bench for gps_sample_packer. Instance dut_a uses the default
//   parameters; dut_b uses FIFO_DEPTH=2 so its SPI side never starts and the
//   FIFO can be driven into overflow. Inputs change and outputs are sampled on
//   the falling clock edge.
module tb_gps_sample_packer;

    logic       clk = 1'b0;
    logic       rst_n_a, rst_n_b;
    logic [3:0] gps_data;
    logic       stb, en_a, en_b;
    logic       sck_a, ss_a, mosi_a, ovf_a;
    logic [4:0] lvl_a;
    logic       sck_b, ss_b, mosi_b, ovf_b;
    logic [1:0] lvl_b;

    int n_checks = 0;
    int n_fail   = 0;

    always #5 clk = ~clk;

    gps_sample_packer dut_a (
        .MCU_CLK_25_000 (clk),
        .RESET_N        (rst_n_a),
        .GPS_DATA       (gps_data),
        .SAMPLE_STB     (stb),
        .ENABLE         (en_a),
        .MCU_SCK        (sck_a),
        .MCU_SS         (ss_a),
        .MCU_MOSI       (mosi_a),
        .OVERFLOW       (ovf_a),
        .FIFO_LEVEL     (lvl_a)
    );

    gps_sample_packer #(.FIFO_DEPTH(2), .WORDS_PER_FRAME(4)) dut_b (
        .MCU_CLK_25_000 (clk),
        .RESET_N        (rst_n_b),
        .GPS_DATA       (gps_data),
        .SAMPLE_STB     (stb),
        .ENABLE         (en_b),
        .MCU_SCK        (sck_b),
        .MCU_SS         (ss_b),
        .MCU_MOSI       (mosi_b),
        .OVERFLOW       (ovf_b),
        .FIFO_LEVEL     (lvl_b)
    );

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    // Data is set 6 edges ahead of the strobe so it has passed the synchroniser.
    task automatic send_sample(input logic [3:0] d);
        gps_data = d;
        repeat (5) @(negedge clk);
        stb = 1'b1;
        @(negedge clk);
        stb = 1'b0;
    endtask

    task automatic send_word(input logic [15:0] w);
        for (int i = 3; i >= 0; i--) send_sample(w[i*4 +: 4]);
    endtask

    // Waits for SS to fall on dut_a, then records one frame and the gap after it.
    task automatic run_frame(input string tag, input logic [63:0] exp_data);
        logic [63:0] data;
        int          low_cyc, rises, gap_hi;
        logic        prev_sck;
        data = '0; low_cyc = 0; rises = 0; gap_hi = 0; prev_sck = 1'b0;
        for (int i = 0; i < 40 && ss_a; i++) @(negedge clk);
        chk({tag, "_start"}, ss_a, 1'b0);
        for (int i = 0; i < 400 && !ss_a; i++) begin
            low_cyc++;
            if (sck_a && !prev_sck) begin
                rises++;
                data = {data[62:0], mosi_a};
            end
            prev_sck = sck_a;
            @(negedge clk);
        end
        chk({tag, "_ss_low_cycles"}, low_cyc, 257);
        chk({tag, "_sck_rises"}, rises, 64);
        chk({tag, "_mosi_data"}, data, exp_data);
        for (int i = 0; i < 4; i++) begin
            if (ss_a) gap_hi++;
            @(negedge clk);
        end
        chk({tag, "_gap_ss_high"}, gap_hi, 4);
        chk({tag, "_level_after"}, lvl_a, 0);
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        rst_n_a = 1'b0; rst_n_b = 1'b0;
        gps_data = 4'h0; stb = 1'b0; en_a = 1'b1; en_b = 1'b0;
        repeat (3) @(negedge clk);
        chk("rst_sck",  sck_a,  1'b0);
        chk("rst_ss",   ss_a,   1'b1);
        chk("rst_mosi", mosi_a, 1'b0);
        chk("rst_ovf",  ovf_a,  1'b0);
        chk("rst_lvl",  lvl_a,  0);
        rst_n_a = 1'b1; rst_n_b = 1'b1;
        @(negedge clk);

        // Packing: A,5,F,0 -> A5F0, level rises on the second edge.
        send_word(16'hA5F0);
        chk("pack_lvl_edge1", lvl_a, 0);
        @(negedge clk);
        chk("pack_lvl_edge2", lvl_a, 1);

        send_word(16'h1234);
        send_word(16'h0000);
        send_word(16'hFFFF);
        run_frame("frame1", 64'hA5F0_1234_0000_FFFF);

        // Partial word 7,7 discarded by a one-cycle ENABLE drop.
        send_sample(4'h7);
        send_sample(4'h7);
        en_a = 1'b0;
        @(negedge clk);
        en_a = 1'b1;
        send_word(16'h1234);
        send_word(16'hCAFE);
        send_word(16'h0F0F);
        send_word(16'h8421);
        run_frame("frame2", 64'h1234_CAFE_0F0F_8421);

        // Push/pop collision on a full FIFO. Frame pop edges relative to the
        // SS-fall edge E0: E0, E0+65, E0+129, E0+193.
        gps_data = 4'h3;
        repeat (3) @(negedge clk);
        stb = 1'b1;
        repeat (16) @(negedge clk);
        stb = 1'b0;
        for (int i = 0; i < 40 && ss_a; i++) @(negedge clk);
        chk("pp_frame_start", ss_a, 1'b0);
        chk("pp_lvl_after_load", lvl_a, 3);
        // Strobes on edges E0+9..E0+64: 13 words fill the FIFO by E0+61 and
        // the 14th completes at E0+64, pushing at E0+65 with the pop.
        repeat (8) @(negedge clk);
        stb = 1'b1;
        repeat (56) @(negedge clk);
        stb = 1'b0;
        chk("pp_lvl_full", lvl_a, 16);
        @(negedge clk);
        chk("pp_lvl_pushpop", lvl_a, 16);
        chk("pp_ovf", ovf_a, 1'b0);

        // Asynchronous reset in the middle of a frame with SCK high.
        for (int i = 0; i < 20 && !sck_a; i++) @(negedge clk);
        chk("pre_rst_sck", sck_a, 1'b1);
        chk("pre_rst_ss", ss_a, 1'b0);
        #2 rst_n_a = 1'b0;
        #1;
        chk("mid_rst_sck",  sck_a,  1'b0);
        chk("mid_rst_ss",   ss_a,   1'b1);
        chk("mid_rst_mosi", mosi_a, 1'b0);
        chk("mid_rst_ovf",  ovf_a,  1'b0);
        chk("mid_rst_lvl",  lvl_a,  0);
        @(negedge clk);

        // Overflow on dut_b (depth 2, frame of 4 never starts).
        en_b = 1'b1;
        send_word(16'h1111);
        send_word(16'h2222);
        @(negedge clk);
        chk("ovf_lvl_2", lvl_b, 2);
        chk("ovf_before", ovf_b, 1'b0);
        send_word(16'h3333);
        @(negedge clk);
        chk("ovf_set", ovf_b, 1'b1);
        chk("ovf_lvl_held", lvl_b, 2);
        send_word(16'h4444);
        repeat (3) @(negedge clk);
        chk("ovf_sticky", ovf_b, 1'b1);
        chk("ovf_lvl_final", lvl_b, 2);
        chk("ovf_ss_idle", ss_b, 1'b1);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
